// File: rtl/sobel_frame_ctrl.sv
// Frame sequencer for the Sobel datapath: raster-scans the pixel store with a
// one-pixel padding border, tags completed 3x3 windows and aligns them to datapath output.
module sobel_frame_ctrl #(
  parameter int IMG_W  = 256,
  parameter int IMG_H  = 256,
  parameter int ADDR_W = 16,
  parameter int CNT_W  = 9,
  parameter int DP_LAT = 3
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              Start,
  input  logic              Hold,
  output logic [ADDR_W-1:0] MemAddr,
  output logic              MemRd,
  output logic              isPadding,
  output logic              DpEn,
  output logic              PixValid,
  output logic              OutValid,
  output logic [CNT_W-1:0]  OutRow,
  output logic [CNT_W-1:0]  OutColumn,
  output logic              isReady,
  output logic              Finish,
  output logic [1:0]        State
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int NSTG  = DP_LAT + 1;
  localparam int DRN_W = $clog2(DP_LAT + 1) + 1;
  localparam logic [DRN_W-1:0] DRN_LAST = DRN_W'(DP_LAT);
  localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(IMG_H);
  localparam logic [CNT_W-1:0] LAST_COL = CNT_W'(IMG_W);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  sr_q, sr_d;
  logic [CNT_W-1:0]  sc_q, sc_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DRN_W-1:0]  drn_q, drn_d;
  logic              pix_q, pix_d;
  logic              vld_q [NSTG];
  logic              vld_d [NSTG];
  logic [CNT_W-1:0]  row_q [NSTG];
  logic [CNT_W-1:0]  row_d [NSTG];
  logic [CNT_W-1:0]  col_q [NSTG];
  logic [CNT_W-1:0]  col_d [NSTG];

  logic             in_img;
  logic             scan_en;
  logic             tag_vld;
  logic [CNT_W-1:0] tag_row;
  logic [CNT_W-1:0] tag_col;

  // Memory-side strobes and the window tag for the position being serviced.
  always_comb begin
    in_img    = (sr_q < LAST_ROW) && (sc_q < LAST_COL);
    scan_en   = (state_q == SCAN) && !Hold;
    MemRd     = scan_en && in_img;
    isPadding = scan_en && !in_img;
    MemAddr   = scan_en ? addr_q : '0;
    DpEn      = !Hold && ((state_q == SCAN) || (state_q == DRAIN));
    tag_vld   = scan_en && (sr_q != '0) && (sc_q != '0);
    tag_row   = sr_q - CNT_W'(1);
    tag_col   = sc_q - CNT_W'(1);
  end

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    sc_d    = sc_q;
    addr_d  = addr_q;
    drn_d   = drn_q;
    unique case (state_q)
      IDLE: begin
        if (Start) begin
          state_d = SCAN;
          sr_d    = '0;
          sc_d    = '0;
          addr_d  = '0;
        end
      end
      SCAN: begin
        if (!Hold) begin
          if (in_img) begin
            addr_d = addr_q + ADDR_W'(1);
          end
          if (sc_q == LAST_COL) begin
            sc_d = '0;
            if (sr_q == LAST_ROW) begin
              state_d = DRAIN;
              drn_d   = '0;
            end else begin
              sr_d = sr_q + CNT_W'(1);
            end
          end else begin
            sc_d = sc_q + CNT_W'(1);
          end
        end
      end
      DRAIN: begin
        if (!Hold) begin
          if (drn_q == DRN_LAST) begin
            state_d = DONE;
          end else begin
            drn_d = drn_q + DRN_W'(1);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Tag and pixel-valid pipelines advance only with the datapath enable.
  always_comb begin
    pix_d = pix_q;
    for (int i = 0; i < NSTG; i++) begin
      vld_d[i] = vld_q[i];
      row_d[i] = row_q[i];
      col_d[i] = col_q[i];
    end
    if (DpEn) begin
      pix_d    = MemRd || isPadding;
      vld_d[0] = tag_vld;
      row_d[0] = tag_row;
      col_d[0] = tag_col;
      for (int i = 1; i < NSTG; i++) begin
        vld_d[i] = vld_q[i-1];
        row_d[i] = row_q[i-1];
        col_d[i] = col_q[i-1];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      sr_q    <= '0;
      sc_q    <= '0;
      addr_q  <= '0;
      drn_q   <= '0;
      pix_q   <= 1'b0;
      for (int i = 0; i < NSTG; i++) begin
        vld_q[i] <= 1'b0;
        row_q[i] <= '0;
        col_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      sc_q    <= sc_d;
      addr_q  <= addr_d;
      drn_q   <= drn_d;
      pix_q   <= pix_d;
      for (int i = 0; i < NSTG; i++) begin
        vld_q[i] <= vld_d[i];
        row_q[i] <= row_d[i];
        col_q[i] <= col_d[i];
      end
    end
  end

  // A stalled last stage still holds its tag, so the strobe is gated by the enable.
  always_comb begin
    OutValid  = vld_q[NSTG-1] && DpEn;
    OutRow    = OutValid ? row_q[NSTG-1] : '0;
    OutColumn = OutValid ? col_q[NSTG-1] : '0;
    PixValid  = pix_q && !Hold;
    isReady   = (state_q == IDLE);
    Finish    = (state_q == DONE);
    State     = state_q;
  end

endmodule
